// File: rtl/if_fetch_stage.sv
// Fetch stage: PC register, IMEM request/ack handshake with one-word hold buffer,
// and the IF/ID pipeline register feeding decode and NPC.
module if_fetch_stage #(
  parameter logic [31:0] PC_RESET = 32'h0000_3000,
  parameter logic [31:0] IMEM_LO  = 32'h0000_3000,
  parameter logic [31:0] IMEM_HI  = 32'h0000_6FFC
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] NPC_pcb_D_i,
  input  logic        CTL_stall_i,
  input  logic        CTL_flush_D_i,
  output logic        IM_req_o,
  output logic [31:0] IM_addr_o,
  input  logic        IM_ack_i,
  input  logic [31:0] IM_rdata_i,
  output logic [31:0] IF_pc_F_o,
  output logic [31:0] IF_pc4_F_o,
  output logic [31:0] IF_pc_D_o,
  output logic [31:0] IF_pc4_D_o,
  output logic [31:0] IF_ir_D_o,
  output logic        IF_vld_D_o,
  output logic        IF_adel_D_o,
  output logic        IF_busy_o
);

  typedef enum logic {S_REQ, S_HELD} state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] buf_q, buf_d;
  logic [31:0] ir_d_q, ir_d_d;
  logic [31:0] pc_d_q, pc_d_d;
  logic [31:0] pc4_d_q, pc4_d_d;
  logic        vld_d_q, vld_d_d;
  logic        adel_d_q, adel_d_d;

  logic [31:0] pc4;
  logic        fault;
  logic        in_req;
  logic        done;
  logic [31:0] src;

  assign pc4    = pc_q + 32'd4;
  assign fault  = (pc_q[1:0] != 2'b00) || (pc_q < IMEM_LO) || (pc_q > IMEM_HI);
  assign in_req = (state_q == S_REQ);
  assign done   = fault || (in_req && IM_ack_i) || !in_req;
  // A faulting fetch never reaches S_HELD, so the buffer is only ever a legal word.
  assign src    = !in_req ? buf_q : (fault ? 32'd0 : IM_rdata_i);

  assign IM_req_o    = in_req && !fault && !reset;
  assign IM_addr_o   = pc_q;
  assign IF_pc_F_o   = pc_q;
  assign IF_pc4_F_o  = pc4;
  assign IF_pc_D_o   = pc_d_q;
  assign IF_pc4_D_o  = pc4_d_q;
  assign IF_ir_D_o   = ir_d_q;
  assign IF_vld_D_o  = vld_d_q;
  assign IF_adel_D_o = adel_d_q;
  assign IF_busy_o   = !done;

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    buf_d    = buf_q;
    ir_d_d   = ir_d_q;
    pc_d_d   = pc_d_q;
    pc4_d_d  = pc4_d_q;
    vld_d_d  = vld_d_q;
    adel_d_d = adel_d_q;

    if (CTL_stall_i) begin
      // Stalled with data arriving: park it so the IMEM ack is not lost.
      if (in_req && IM_ack_i && !fault) begin
        buf_d   = IM_rdata_i;
        state_d = S_HELD;
      end
    end else if (done) begin
      pc_d    = NPC_pcb_D_i;
      state_d = S_REQ;
      if (CTL_flush_D_i) begin
        ir_d_d   = 32'd0;
        vld_d_d  = 1'b0;
        adel_d_d = 1'b0;
      end else begin
        ir_d_d   = src;
        pc_d_d   = pc_q;
        pc4_d_d  = pc4;
        vld_d_d  = 1'b1;
        adel_d_d = fault;
      end
    end else begin
      ir_d_d   = 32'd0;
      vld_d_d  = 1'b0;
      adel_d_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_REQ;
      pc_q     <= PC_RESET;
      buf_q    <= 32'd0;
      ir_d_q   <= 32'd0;
      pc_d_q   <= PC_RESET;
      pc4_d_q  <= PC_RESET + 32'd4;
      vld_d_q  <= 1'b0;
      adel_d_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      buf_q    <= buf_d;
      ir_d_q   <= ir_d_d;
      pc_d_q   <= pc_d_d;
      pc4_d_q  <= pc4_d_d;
      vld_d_q  <= vld_d_d;
      adel_d_q <= adel_d_d;
    end
  end

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed testbench for if_fetch_stage: zero-wait fetch, wait states, stall capture,
// redirect/flush, address faults and asynchronous reset during an outstanding fetch.
module tb_if_fetch_stage;

  logic        clk;
  logic        reset;
  logic [31:0] npc;
  logic        stall;
  logic        flush;
  logic        im_req;
  logic [31:0] im_addr;
  logic        im_ack;
  logic [31:0] im_rdata;
  logic [31:0] pc_f;
  logic [31:0] pc4_f;
  logic [31:0] pc_d;
  logic [31:0] pc4_d;
  logic [31:0] ir_d;
  logic        vld_d;
  logic        adel_d;
  logic        busy;

  int check_count = 0;
  int error_count = 0;

  if_fetch_stage dut (
    .clk          (clk),
    .reset        (reset),
    .NPC_pcb_D_i  (npc),
    .CTL_stall_i  (stall),
    .CTL_flush_D_i(flush),
    .IM_req_o     (im_req),
    .IM_addr_o    (im_addr),
    .IM_ack_i     (im_ack),
    .IM_rdata_i   (im_rdata),
    .IF_pc_F_o    (pc_f),
    .IF_pc4_F_o   (pc4_f),
    .IF_pc_D_o    (pc_d),
    .IF_pc4_D_o   (pc4_d),
    .IF_ir_D_o    (ir_d),
    .IF_vld_D_o   (vld_d),
    .IF_adel_D_o  (adel_d),
    .IF_busy_o    (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    check_count++;
    if (observed !== expected) begin
      error_count++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic s, input logic f, input logic a,
                               input logic [31:0] rd, input logic [31:0] n);
    stall    = s;
    flush    = f;
    im_ack   = a;
    im_rdata = rd;
    npc      = n;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkD(input string tag, input logic [31:0] ir, input logic [31:0] pc,
                        input logic vld, input logic adel);
    checkOutput({tag, "_ir"},   ir_d,   ir);
    checkOutput({tag, "_pcD"},  pc_d,   pc);
    checkOutput({tag, "_pc4D"}, pc4_d,  pc + 32'd4);
    checkOutput({tag, "_vld"},  {31'd0, vld_d},  {31'd0, vld});
    checkOutput({tag, "_adel"}, {31'd0, adel_d}, {31'd0, adel});
  endtask

  initial begin
    reset = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    #1;
    checkOutput("rst_pcF",  pc_f,  32'h3000);
    checkOutput("rst_pc4F", pc4_f, 32'h3004);
    checkOutput("rst_req",  {31'd0, im_req}, 32'd0);
    checkD("rst", 32'd0, 32'h3000, 1'b0, 1'b0);
    @(negedge clk);
    reset = 1'b0;

    // T1: zero-wait sequential fetch
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b1, 32'hA000_0000 + i, 32'h3004 + 32'(4 * i));
      checkOutput("t1_addr", im_addr, 32'h3000 + 32'(4 * i));
      checkOutput("t1_req",  {31'd0, im_req}, 32'd1);
      checkOutput("t1_busy", {31'd0, busy},   32'd0);
      tick();
      checkD("t1", 32'hA000_0000 + i, 32'h3000 + 32'(4 * i), 1'b1, 1'b0);
    end
    checkOutput("t1_pcF", pc_f, 32'h300C);

    // T2: two wait states after a fresh reset
    reset = 1'b1;
    #2;
    checkOutput("t2_rst_pcF", pc_f, 32'h3000);
    checkOutput("t2_rst_vld", {31'd0, vld_d}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 2; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b0, 32'hBAD0_0000, 32'h3004);
      checkOutput("t2_busy", {31'd0, busy},   32'd1);
      checkOutput("t2_req",  {31'd0, im_req}, 32'd1);
      tick();
      checkD("t2_bubble", 32'd0, 32'h3000, 1'b0, 1'b0);
      checkOutput("t2_pcF_hold", pc_f, 32'h3000);
    end
    applyStimulus(1'b0, 1'b0, 1'b1, 32'hC0DE_0001, 32'h3004);
    checkOutput("t2_busy_ack", {31'd0, busy}, 32'd0);
    tick();
    checkD("t2", 32'hC0DE_0001, 32'h3000, 1'b1, 1'b0);
    checkOutput("t2_pcF", pc_f, 32'h3004);

    // T3: ack during stall is buffered, delivered once stall drops
    applyStimulus(1'b1, 1'b0, 1'b1, 32'h2408_000A, 32'h3008);
    checkOutput("t3_busy", {31'd0, busy}, 32'd0);
    tick();
    checkOutput("t3_req_held", {31'd0, im_req}, 32'd0);
    checkOutput("t3_pcF_hold", pc_f, 32'h3004);
    checkD("t3_hold", 32'hC0DE_0001, 32'h3000, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 32'hDEAD_BEEF, 32'h3008);
    checkOutput("t3_busy_held", {31'd0, busy}, 32'd0);
    tick();
    checkD("t3", 32'h2408_000A, 32'h3004, 1'b1, 1'b0);
    checkOutput("t3_pcF", pc_f, 32'h3008);
    checkOutput("t3_req", {31'd0, im_req}, 32'd1);

    // T4: redirect with flush, then stall overriding flush
    applyStimulus(1'b0, 1'b1, 1'b1, 32'h1234_5678, 32'h3100);
    tick();
    checkOutput("t4_addr", im_addr, 32'h3100);
    checkD("t4_flush", 32'd0, 32'h3004, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1, 32'h4444_0004, 32'h3104);
    tick();
    checkD("t4_adv", 32'h4444_0004, 32'h3100, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h5555_5555, 32'h3200);
    tick();
    checkOutput("t4_stall_addr", im_addr, 32'h3104);
    checkD("t4_stall", 32'h4444_0004, 32'h3100, 1'b1, 1'b0);

    // T5: misaligned and out-of-range fetch addresses
    applyStimulus(1'b0, 1'b0, 1'b1, 32'h6666_0006, 32'h3102);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h7777_7777, 32'h7000);
    checkOutput("t5_mis_req",  {31'd0, im_req}, 32'd0);
    checkOutput("t5_mis_busy", {31'd0, busy},   32'd0);
    tick();
    checkD("t5_mis", 32'd0, 32'h3102, 1'b1, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b1, 32'h8888_8888, 32'h3000);
    checkOutput("t5_hi_req",  {31'd0, im_req}, 32'd0);
    checkOutput("t5_hi_busy", {31'd0, busy},   32'd0);
    tick();
    checkD("t5_hi", 32'd0, 32'h7000, 1'b1, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b1, 32'h9999_0009, 32'h6FFC);
    tick();
    checkD("t5_ok", 32'h9999_0009, 32'h3000, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 32'd0, 32'h7000);
    checkOutput("t5_top_req", {31'd0, im_req}, 32'd1);
    checkOutput("t5_top_busy", {31'd0, busy},  32'd1);

    // T6: asynchronous reset while a request is pending
    #1;
    reset  = 1'b1;
    im_ack = 1'b1;
    im_rdata = 32'hBBBB_BBBB;
    #1;
    checkOutput("t6_pcF", pc_f, 32'h3000);
    checkOutput("t6_req", {31'd0, im_req}, 32'd0);
    checkD("t6_rst", 32'd0, 32'h3000, 1'b0, 1'b0);
    tick();
    checkOutput("t6_pcF_edge", pc_f, 32'h3000);
    checkOutput("t6_vld_edge", {31'd0, vld_d}, 32'd0);
    #2;
    reset = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b1, 32'hCAFE_0000, 32'h3004);
    checkOutput("t6_req_after", {31'd0, im_req}, 32'd1);
    tick();
    checkD("t6", 32'hCAFE_0000, 32'h3000, 1'b1, 1'b0);
    checkOutput("t6_pcF_after", pc_f, 32'h3004);

    $display("CHECKS %0d ERRORS %0d", check_count, error_count);
    $finish;
  end

endmodule
